// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the keypad scanner and its consumers.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 3;
  localparam int unsigned KEY_W    = 12;

  // Keys the maze game uses for up / left / right / down.
  localparam int unsigned KEY_1 = 1;
  localparam int unsigned KEY_3 = 3;
  localparam int unsigned KEY_5 = 5;
  localparam int unsigned KEY_7 = 7;

  // Position of a matrix switch in the flat key vector.
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return 4'(row) * 4'(NUM_COLS) + 4'(col);
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus the key vector handed to the game logic.
interface keypad_scan_if;

  logic [keypad_pkg::NUM_ROWS-1:0] key_row;
  logic                            clr;
  logic [keypad_pkg::NUM_COLS-1:0] key_col;
  logic [keypad_pkg::KEY_W-1:0]    key;
  logic [keypad_pkg::KEY_W-1:0]    key_latch;
  logic                            key_press;

  // Board / consumer side.
  modport master (
    output key_row,
    output clr,
    input  key_col,
    input  key,
    input  key_latch,
    input  key_press
  );

  // Scanner side.
  modport slave (
    input  key_row,
    input  clr,
    output key_col,
    output key,
    output key_latch,
    output key_press
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back stages to resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad column scanner with frame-level debounce and a sticky press latch.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.slave  kp
);

  localparam int unsigned DWELL_W  = $clog2(SCAN_DIV);
  localparam int unsigned STABLE_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(SCAN_DIV - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_SCANS - 1);
  localparam logic [1:0]          COL_LAST    = 2'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] row_sync;
  logic [DWELL_W-1:0]  dwell_q;
  logic [1:0]          col_q;
  logic [KEY_W-1:0]    frame_q;
  logic [KEY_W-1:0]    ref_q;
  logic [STABLE_W-1:0] stable_q;
  logic                commit_q;
  logic [KEY_W-1:0]    key_q;
  logic [KEY_W-1:0]    latch_q;
  logic                press_q;

  logic                sample;
  logic                frame_done;
  logic [KEY_W-1:0]    frame_d;
  logic [STABLE_W-1:0] stable_d;
  logic [KEY_W-1:0]    rise;
  logic [KEY_W-1:0]    latch_d;

  sync_2ff #(
    .WIDTH (NUM_ROWS)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kp.key_row),
    .q     (row_sync)
  );

  // Frame assembly, debounce comparison and rising-edge detection.
  always_comb begin
    sample     = (dwell_q == DWELL_LAST);
    frame_done = sample && (col_q == COL_LAST);
    frame_d    = frame_q;
    if (sample) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        frame_d[key_index(2'(r), col_q)] = row_sync[r];
      end
    end
    if (frame_d == ref_q) begin
      stable_d = (stable_q == STABLE_LAST) ? stable_q : stable_q + 1'b1;
    end else begin
      stable_d = '0;
    end
    // ref_q holds the frame being committed while commit_q is high.
    rise    = commit_q ? (ref_q & ~key_q) : '0;
    latch_d = (kp.clr ? '0 : latch_q) | rise;
  end

  // Scan counters, debounce state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q  <= '0;
      col_q    <= '0;
      frame_q  <= '0;
      ref_q    <= '0;
      stable_q <= '0;
      commit_q <= 1'b0;
      key_q    <= '0;
      latch_q  <= '0;
      press_q  <= 1'b0;
    end else begin
      dwell_q <= sample ? '0 : dwell_q + 1'b1;
      if (sample) begin
        col_q   <= (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;
        frame_q <= frame_d;
      end
      commit_q <= 1'b0;
      if (frame_done) begin
        // On a mismatch the new frame becomes the reference; on a match it is unchanged.
        ref_q    <= frame_d;
        stable_q <= stable_d;
        commit_q <= (stable_d == STABLE_LAST);
      end
      if (commit_q) begin
        key_q <= ref_q;
      end
      press_q <= |rise;
      latch_q <= latch_d;
    end
  end

  assign kp.key_col   = 3'b001 << col_q;
  assign kp.key       = key_q;
  assign kp.key_latch = latch_q;
  assign kp.key_press = press_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans the 4x3 push-button keypad matrix, debounces it and presents a 12-bit key vector to the maze-game logic, which consumes it as `key[11:0]` on its 1 s game tick. Because the game samples only once per second, the block provides both a debounced level vector and a sticky latch of new presses, cleared by the consumer. It runs entirely on the fast system clock and sits between the board keypad pins and the game/display stage.

## Interface
Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven; minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix frames required before `key` updates; minimum 1.

Ports (reset reset, asynchronous, active-high; clock clk):
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- key_row  input  4  keypad row sense lines, active-high, asynchronous to clk
- clr  input  1  one-cycle pulse; clears `key_latch`
- key_col  output  3  one-hot column drive, active-high
- key  output  12  debounced level vector; bit index = row*3 + col
- key_latch  output  12  sticky OR of key rising edges since last `clr`
- key_press  output  1  one-cycle pulse when any bit of `key` rises

## Operation
- `key_row` passes through a 2-flop synchronizer before use.
- Scan: column index `c` cycles 0→1→2→0; `key_col = 1 << c`. Dwell counter runs 0..SCAN_DIV-1 per column, then wraps and advances `c`.
- Sample: when dwell == SCAN_DIV-1, synchronized rows are written into frame bits {r*3+c : r=0..3}. This allows 2 sync cycles plus settling after the column switch.
- Frame complete: the sample at c==2. The completed frame is compared with the previous completed frame:
  - Equal: `stable_cnt` increments, saturating at DEBOUNCE_SCANS-1.
  - Different: `stable_cnt` = 0, and the frame becomes the new reference.
- Commit: when a frame completes with `stable_cnt` reaching DEBOUNCE_SCANS-1, `key` ← frame. With DEBOUNCE_SCANS=1, every frame commits.
- Rising set: `rise = new_key & ~key`.
  - `key_press` = 1 for the commit cycle's following cycle when `rise != 0`.
  - `key_latch` ← (clr ? 0 : key_latch) | rise. On simultaneous clr and rise, the rise bits survive.
- Multiple simultaneous keys are reported as-is. Priority and ghosting are the consumer's concern.
- Releases clear `key` bits after the same debounce. Releases do not affect `key_latch`.

## Timing
- Reset values:
  - `key_col`=3'b001, `key`=0, `key_latch`=0, `key_press`=0.
  - Dwell=0, c=0, `stable_cnt`=0, reference frame=0.
- Frame period: 3*SCAN_DIV cycles.
- Press latency from a stable pin to the `key` update: at most 2 sync cycles + (DEBOUNCE_SCANS+1) frames.
- `key`, `key_latch` and `key_press` all update on the same clk edge, one cycle after the completing sample.
- A bounce in any frame restarts the DEBOUNCE_SCANS count. `key` never shows an intermediate value.
- Reset mid-scan: all state returns to reset values immediately, and scanning restarts at column 0 on the first edge after deassertion.
- `clr` is accepted on any cycle; `key_latch` reads 0 on the next cycle unless a simultaneous rise occurred.

## Structure
- Package `keypad_pkg`:
  - NUM_ROWS=4, NUM_COLS=3, KEY_W=12.
  - Key index constants KEY_1=1, KEY_3=3, KEY_5=5, KEY_7=7 (the game's up/left/right/down usage).
- Sub-module `sync_2ff`, parameterized by width, for `key_row`. All remaining logic stays flat in `keypad_scan`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 12-cycle frame.
- Reset then idle:
  - `key_col` sequence is 001 for 4 cycles, 010 for 4, 100 for 4, repeating.
  - `key`=0, `key_press` never asserts.
- Hold row1 high while col1 is driven (key 4), clean:
  - `key`=12'h010 within 2+4 frames.
  - `key_press` is exactly one 1-cycle pulse, and `key_latch`=12'h010.
- Bounce on key 1 (row0/col1):
  - Toggle every 7 cycles for 40 cycles, then hold. `key` stays 0 until 3 identical frames after the hold.
  - Then `key`=12'h002.
- Press key 7 then release:
  - `key` returns to 0 after debounce, while `key_latch` stays 12'h080.
  - `clr` pulse → `key_latch`=0 next cycle.
- `clr` asserted on the same cycle as the key 5 commit:
  - `key_latch`=12'h020, not 0.
- Hold key 3 and key 5 together → `key`=12'h028; assert reset mid-frame → all outputs return to reset values at once and scanning resumes at 001.
